// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result path.
//   sink_state_e : result sink FSM states
//   RES_W        : result word width (8 int8 lanes)
//   ADDR_W       : result SRAM address width
//   pack_lanes   : packs N int8 lanes into one result word, lane i at [8i+7:8i]
package sa_pkg;

    localparam int unsigned RES_W  = 64;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned LANES  = RES_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        DRAIN   = 2'd3
    } sink_state_e;

    // Lane i of the packed array lands on bits [8i+7:8i] of the result word.
    function automatic logic [RES_W-1:0] pack_lanes(input logic [LANES-1:0][7:0] lanes);
        logic [RES_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            r[8*i +: 8] = lanes[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sa_skid_fifo.sv
// Two-entry valid/ready buffer. Entry 0 is always the head, so out_data and
// out_valid come straight from flops. The producer is credit-based: it must
// only push when count (after any pop this cycle) leaves room; a push into a
// full buffer without a pop is dropped.
//   in_valid/in_data   : push side
//   out_valid/out_ready/out_data : pop side
//   count              : current occupancy (0..2)
module sa_skid_fifo #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;
    logic         pop;

    // Next-state: shift e1 into the head on pop, append at the tail on push.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        pop     = valid_q && out_ready;
        case ({in_valid, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_d    = in_data;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    e1_d    = in_data;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = in_data;
                end else begin
                    e0_d = in_data;
                end
            end
            default: ;
        endcase
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = e0_q;
    assign count     = count_q;

endmodule

// File: rtl/sa_result_sink.sv
// Result sink: captures SA result rows into the output SRAM, then drains
// address 0 .. hwm-1 as a valid/ready stream. Owns the SRAM's single port.
//   start, done_all, wen_n_in/waddr_in/data_in : job control and SA write-out
//   sram_*                                      : output SRAM port (1-cycle read)
//   m_valid/m_ready/m_data/m_last               : drain stream
//   busy, drain_done, err_stray                 : status
module sa_result_sink
    import sa_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              done_all,
    input  logic              wen_n_in,
    input  logic [ADDR_W-1:0] waddr_in,
    input  logic [N*8-1:0]    data_in,
    output logic              sram_wen_n,
    output logic              sram_ren_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [RES_W-1:0]  sram_wdata,
    input  logic [RES_W-1:0]  sram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [RES_W-1:0]  m_data,
    output logic              m_last,
    output logic              busy,
    output logic              drain_done,
    output logic              err_stray
);

    // One extra bit so hwm/rptr can reach 2^ADDR_W without wrapping.
    localparam int unsigned PTR_W = ADDR_W + 1;

    sink_state_e       state_q, state_d;
    logic [PTR_W-1:0]  hwm_q, hwm_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic              has_data_q, has_data_d;
    logic              err_stray_q, err_stray_d;
    logic              sram_wen_n_q, sram_wen_n_d;
    logic              sram_ren_n_q, sram_ren_n_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [RES_W-1:0]  sram_wdata_q, sram_wdata_d;
    logic              issue_last_q, issue_last_d;
    logic              rd_ret_q, rd_ret_d;
    logic              ret_last_q, ret_last_d;
    logic              drain_done_q, drain_done_d;
    logic              busy_q, busy_d;

    logic              fifo_valid;
    logic [RES_W:0]    fifo_data;
    logic [1:0]        fifo_count;
    logic              beat_acc;
    logic [2:0]        occ;
    logic              rd_credit;
    logic [PTR_W-1:0]  wr_hwm;

    assign beat_acc = fifo_valid && m_ready;

    // Buffer slots already promised: held beats plus reads still in the SRAM
    // pipe. A beat leaving this cycle frees its slot before any new read lands.
    assign occ       = 3'(fifo_count) + 3'(!sram_ren_n_q) + 3'(rd_ret_q);
    assign rd_credit = (occ < (3'd2 + 3'(beat_acc)));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        hwm_d        = hwm_q;
        rptr_d       = rptr_q;
        has_data_d   = has_data_q;
        err_stray_d  = err_stray_q;
        sram_wen_n_d = 1'b1;
        sram_ren_n_d = 1'b1;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        issue_last_d = 1'b0;
        drain_done_d = 1'b0;
        rd_ret_d     = !sram_ren_n_q;
        ret_last_d   = issue_last_q;
        wr_hwm       = PTR_W'(waddr_in) + PTR_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CAPTURE;
                    hwm_d       = '0;
                    has_data_d  = 1'b0;
                    err_stray_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (!wen_n_in) begin
                    sram_wen_n_d = 1'b0;
                    sram_addr_d  = waddr_in;
                    sram_wdata_d = pack_lanes(data_in);
                    has_data_d   = 1'b1;
                    if (wr_hwm > hwm_q) begin
                        hwm_d = wr_hwm;
                    end
                end
                if (done_all) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Lets the final registered write reach the SRAM.
                rptr_d = '0;
                if (has_data_q) begin
                    state_d = DRAIN;
                end else begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            DRAIN: begin
                if (rd_credit && (rptr_q < hwm_q)) begin
                    sram_ren_n_d = 1'b0;
                    sram_addr_d  = rptr_q[ADDR_W-1:0];
                    issue_last_d = (rptr_q == (hwm_q - PTR_W'(1)));
                    rptr_d       = rptr_q + PTR_W'(1);
                end
                if (beat_acc && fifo_data[RES_W]) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strobe outside CAPTURE never reaches the SRAM; it only flags.
        if (!wen_n_in && (state_q != CAPTURE)) begin
            err_stray_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hwm_q        <= '0;
            rptr_q       <= '0;
            has_data_q   <= 1'b0;
            err_stray_q  <= 1'b0;
            sram_wen_n_q <= 1'b1;
            sram_ren_n_q <= 1'b1;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            issue_last_q <= 1'b0;
            rd_ret_q     <= 1'b0;
            ret_last_q   <= 1'b0;
            drain_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hwm_q        <= hwm_d;
            rptr_q       <= rptr_d;
            has_data_q   <= has_data_d;
            err_stray_q  <= err_stray_d;
            sram_wen_n_q <= sram_wen_n_d;
            sram_ren_n_q <= sram_ren_n_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            issue_last_q <= issue_last_d;
            rd_ret_q     <= rd_ret_d;
            ret_last_q   <= ret_last_d;
            drain_done_q <= drain_done_d;
            busy_q       <= busy_d;
        end
    end

    // Returned words carry their last-beat tag alongside the data.
    sa_skid_fifo #(
        .W (RES_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_ret_q),
        .in_data   ({ret_last_q, sram_rdata}),
        .out_valid (fifo_valid),
        .out_ready (m_ready),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    assign sram_wen_n = sram_wen_n_q;
    assign sram_ren_n = sram_ren_n_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign m_valid    = fifo_valid;
    assign m_data     = fifo_data[RES_W-1:0];
    assign m_last     = fifo_data[RES_W];
    assign busy       = busy_q;
    assign drain_done = drain_done_q;
    assign err_stray  = err_stray_q;

endmodule

// File: tb/tb_sa_result_sink.sv
// Directed bench for sa_result_sink with a behavioural 1-cycle-read SRAM.
module tb_sa_result_sink;

    localparam int unsigned AW    = 13;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          done_all = 1'b0;
    logic          wen_n_in = 1'b1;
    logic [AW-1:0] waddr_in = '0;
    logic [63:0]   data_in = '0;
    logic          sram_wen_n;
    logic          sram_ren_n;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_wdata;
    logic [63:0]   sram_rdata;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [63:0]   m_data;
    logic          m_last;
    logic          busy;
    logic          drain_done;
    logic          err_stray;

    int n_assert = 0;
    int n_fail   = 0;

    sa_result_sink #(.N(8), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .done_all   (done_all),
        .wen_n_in   (wen_n_in),
        .waddr_in   (waddr_in),
        .data_in    (data_in),
        .sram_wen_n (sram_wen_n),
        .sram_ren_n (sram_ren_n),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .drain_done (drain_done),
        .err_stray  (err_stray)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hole(input int unsigned a);
        return 64'hA5A5_0000_0000_0000 | 64'(a);
    endfunction

    // SRAM model: unwritten words read back as an address-tagged pattern.
    logic [63:0] mem    [DEPTH];
    bit          wr_bit [DEPTH];
    logic [63:0] rdata_r = '0;
    always @(posedge clk) begin
        if (!sram_wen_n) begin
            mem[sram_addr]    <= sram_wdata;
            wr_bit[sram_addr] <= 1'b1;
        end
        if (!sram_ren_n) rdata_r <= wr_bit[sram_addr] ? mem[sram_addr] : hole(32'(sram_addr));
    end
    assign sram_rdata = rdata_r;

    // Bench's own record of what each job intended to write.
    logic [63:0] exp_mem [DEPTH];
    bit          exp_wr  [DEPTH];

    function automatic logic [63:0] exp_val(input int unsigned a);
        return exp_wr[a] ? exp_mem[a] : hole(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Negedge monitor: beat capture, stall stability, outstanding reads.
    logic [64:0] beat_q [$];
    int          cyc = 0, wr_cnt = 0, mvalid_cnt = 0, done_cnt = 0;
    int          done_cyc = 0, last_acc_cyc = 0;
    int          rd_issued = 0, acc = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!sram_wen_n) wr_cnt++;
        if (m_valid) mvalid_cnt++;
        if (drain_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!rst_n) begin
            rd_issued  = 0;
            acc        = 0;
            prev_stall = 1'b0;
        end else begin
            if (!sram_ren_n) begin
                rd_issued++;
                check("outstanding_le2", 64'((rd_issued - acc) <= 2), 64'd1);
            end
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_data", m_data, prev_data);
                check("stall_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
                beat_q.push_back({m_last, m_data});
                acc++;
                if (m_last) last_acc_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        beat_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cyc_write(input int unsigned a, input logic [63:0] d, input bit done);
        wen_n_in   = 1'b0;
        waddr_in   = AW'(a);
        data_in    = d;
        done_all   = done;
        exp_mem[a] = d;
        exp_wr[a]  = 1'b1;
        tick();
    endtask

    task automatic end_writes();
        wen_n_in = 1'b1;
        done_all = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input bit toggle, input string tag);
        int          c0 = done_cnt;
        int          i = 0;
        logic [3:0]  pat = 4'b1001;
        while (done_cnt == c0 && i < max_cyc) begin
            if (toggle) m_ready = pat[i % 4];
            tick();
            i++;
        end
        m_ready = 1'b1;
        check({tag, "_done_seen"}, 64'(done_cnt != c0), 64'd1);
    endtask

    task automatic check_beats(input string tag, input int n);
        int bad = 0;
        int lim;
        logic [64:0] e;
        check({tag, "_beats"}, 64'(beat_q.size()), 64'(n));
        lim = (beat_q.size() < n) ? beat_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            e = {(i == n - 1), exp_val(32'(i))};
            if (beat_q[i] !== e) bad++;
        end
        check({tag, "_bad_beats"}, 64'(bad), 64'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"},
              64'({sram_wen_n, sram_ren_n, sram_addr, m_valid, m_last, busy, drain_done, err_stray}),
              64'({1'b1, 1'b1, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        check({tag, "_wdata"}, sram_wdata, 64'd0);
        check({tag, "_mdata"}, m_data, 64'd0);
    endtask

    int w0, m0;

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outs("reset");
        rst_n = 1'b1;
        tick();
        check_reset_outs("post_reset");

        // Basic job: addrs 0..3, last write together with done_all
        w0 = wr_cnt;
        start_job();
        cyc_write(0, 64'h0101_0101_0101_0101, 1'b0);
        check("first_write_en", 64'(sram_wen_n), 64'd0);
        check("first_write_addr", 64'(sram_addr), 64'd0);
        check("first_write_data", sram_wdata, 64'h0101_0101_0101_0101);
        for (int k = 2; k <= 4; k++) cyc_write(32'(k - 1), 64'h0101_0101_0101_0101 * 64'(k), (k == 4));
        end_writes();
        wait_drain(200, 1'b0, "basic");
        check_beats("basic", 4);
        check("basic_done_latency", 64'(done_cyc - last_acc_cyc), 64'd1);
        check("basic_writes", 64'(wr_cnt - w0), 64'd4);

        // Backpressure: m_ready pattern 1,0,0,1
        start_job();
        for (int k = 1; k <= 4; k++) cyc_write(32'(k - 1), 64'h0101_0101_0101_0101 * 64'(k + 4), (k == 4));
        end_writes();
        wait_drain(400, 1'b1, "bp");
        check_beats("bp", 4);

        // Sparse / high-water: addr 5 then addr 2
        start_job();
        cyc_write(5, 64'hC0FF_EE00_0000_0005, 1'b0);
        cyc_write(2, 64'hBEEF_0000_0000_0002, 1'b1);
        end_writes();
        wait_drain(200, 1'b0, "sparse");
        check_beats("sparse", 6);

        // Empty job
        m0 = mvalid_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_busy_capture", 64'(busy), 64'd1);
        done_all = 1'b1;
        tick();
        done_all = 1'b0;
        check("empty_busy_flush", 64'(busy), 64'd1);
        tick();
        check("empty_idle", 64'({busy, drain_done}), 64'b01);
        tick();
        check("empty_done_pulse", 64'(drain_done), 64'd0);
        check("empty_no_valid", 64'(mvalid_cnt - m0), 64'd0);

        // Stray strobe in IDLE
        w0 = wr_cnt;
        wen_n_in = 1'b0;
        waddr_in = 13'd7;
        data_in  = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        wen_n_in = 1'b1;
        check("stray_idle_flag", 64'(err_stray), 64'd1);
        tick();
        check("stray_idle_nowrite", 64'(wr_cnt - w0), 64'd0);

        // Job with start and a stray strobe during DRAIN
        start_job();
        check("start_clears_err", 64'(err_stray), 64'd0);
        w0 = wr_cnt;
        cyc_write(0, 64'h1111_2222_3333_4444, 1'b0);
        cyc_write(1, 64'h5555_6666_7777_8888, 1'b1);
        end_writes();
        tick();
        start    = 1'b1;
        wen_n_in = 1'b0;
        waddr_in = 13'd1;
        data_in  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        start    = 1'b0;
        wen_n_in = 1'b1;
        check("drain_start_ignored", 64'(busy), 64'd1);
        wait_drain(200, 1'b0, "stray");
        check_beats("stray", 2);
        check("stray_drain_flag", 64'(err_stray), 64'd1);
        check("stray_drain_writes", 64'(wr_cnt - w0), 64'd2);

        // Reset mid-DRAIN after two beats
        start_job();
        check("restart_clears_err", 64'(err_stray), 64'd0);
        for (int k = 0; k < 6; k++) cyc_write(32'(k), 64'h7700_0000_0000_0000 | 64'(k), (k == 5));
        end_writes();
        for (int i = 0; i < 100 && beat_q.size() < 2; i++) tick();
        check("midreset_two_beats", 64'(beat_q.size() >= 2), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midreset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_job();
        cyc_write(0, 64'h0A0A_0000_0000_0000, 1'b0);
        cyc_write(1, 64'h0B0B_0000_0000_0001, 1'b1);
        end_writes();
        wait_drain(200, 1'b0, "after_reset");
        check_beats("after_reset", 2);

        // Top address: hwm = 2^ADDR_W, pointer must not wrap
        start_job();
        cyc_write(DEPTH - 1, 64'hFEED_FACE_CAFE_F00D, 1'b1);
        end_writes();
        wait_drain(20000, 1'b0, "top");
        check_beats("top", int'(DEPTH));
        check("top_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_result_sink.md
Name: sa_result_sink

Overview:
- Captures the quantized result rows produced by the systolic tile controller (wen_n / waddr / 8×int8 data) into a single-port 64-bit output SRAM.
- After the tile controller signals done_all, drains the written region, address 0 up to the high-water mark, as a valid/ready stream toward the DMA/host side.
- Sits between the SA write-out interface and the output SRAM, and owns that SRAM's only port.

Parameters:
- N, 8, number of int8 lanes per result word; N*8 must equal 64.
- ADDR_W, 13, result SRAM address width; matches the SA waddr width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; arms capture, clears the high-water mark and err_stray; honoured only in IDLE
- done_all  in  1  pulse from the SA controller; last result of the job has been presented
- wen_n_in  in  1  active-low write strobe from the SA controller
- waddr_in  in  ADDR_W  SA result word address
- data_in  in  N×8  quantized result word; lane i occupies bits [8i+7:8i]
- sram_wen_n  out  1  active-low SRAM write enable
- sram_ren_n  out  1  active-low SRAM read enable; read data is valid exactly 1 cycle later
- sram_addr  out  ADDR_W  shared SRAM address
- sram_wdata  out  64  SRAM write data
- sram_rdata  in  64  SRAM read data
- m_valid  out  1  stream beat valid
- m_ready  in  1  stream beat accepted when m_valid && m_ready
- m_data  out  64  stream payload
- m_last  out  1  high on the final beat
- busy  out  1  high whenever state != IDLE
- drain_done  out  1  one-cycle pulse when the job completes
- err_stray  out  1  sticky flag: a write strobe arrived outside CAPTURE

Behaviour:
- Reset values: all outputs 0, except sram_wen_n=1 and sram_ren_n=1. State = IDLE, skid FIFO empty, hwm cleared.
- FSM states: IDLE, CAPTURE, FLUSH, DRAIN.
- IDLE→CAPTURE on start. start in any other state is ignored.
- CAPTURE:
  - Each cycle with wen_n_in=0 is registered. The next cycle drives sram_wen_n=0, sram_addr=waddr_in, sram_wdata=data_in. Write latency is 1 cycle; back-to-back writes run at full rate.
  - hwm = max(hwm, waddr_in+1), computed ADDR_W+1 bits wide. A flag has_data is set on the first write.
- CAPTURE→FLUSH on done_all. A write strobe in the same cycle as done_all is still captured.
- FLUSH lasts exactly 1 cycle so the last registered write lands; no read is issued.
  - FLUSH→DRAIN if has_data.
  - Otherwise FLUSH→IDLE with a drain_done pulse and zero beats emitted.
- DRAIN:
  - Read pointer rptr starts at 0.
  - Issue a read (sram_ren_n=0, sram_addr=rptr) when rptr < hwm and (fifo_count + reads_in_flight) < 2.
  - Returned data is pushed into a 2-entry skid FIFO whose head drives m_data/m_valid. This gives full throughput with m_ready held high and no data loss under any m_ready pattern.
  - m_data and m_last must hold stable while m_valid && !m_ready.
  - m_last = 1 on the beat read from address hwm-1.
  - When the m_last beat is accepted: pulse drain_done, go to IDLE. FIFO is empty by construction at that point.
- wen_n_in=0 in IDLE, FLUSH or DRAIN: the SRAM is not written and err_stray is set. err_stray is cleared only by start or reset.
- SRAM port conflict is impossible by construction: writes occur only in CAPTURE and the cycle after, reads only in DRAIN.
- hwm = 2^ADDR_W (address 8191 written) is legal; rptr must not wrap.
- Unwritten holes below hwm are drained with whatever the SRAM contains. No zero-fill.
- Reset mid-operation: immediate return to IDLE, outputs to reset values. Any in-flight read is discarded.

Decomposition:
- Shared package sa_pkg: sink_state_e enum (IDLE, CAPTURE, FLUSH, DRAIN), localparam RES_W=64, ADDR_W=13, and a lane-pack helper function (N×8 → 64).
- One sub-module: sa_skid_fifo, a 2-entry valid/ready buffer with count output. Reusable on the SA operand loader side.

Test Plan:
- Basic job: start; write addrs 0..3 with data 64'h0101…×k (k=1..4); done_all with the last write → exactly 4 beats in order, m_last on beat 4, drain_done 1 cycle after acceptance.
- Backpressure: same job with m_ready toggling 1,0,0,1,… → m_data stable while stalled, no beat lost or duplicated, reads never exceed 2 outstanding.
- Sparse/high-water: writes to addr 5 then addr 2 only → 6 beats, with addr 2 and 5 carrying the written data; hwm=6.
- Empty job: start then done_all with no writes → busy for 2 cycles, drain_done pulse, m_valid never asserted.
- Stray/ignored: wen_n_in=0 in IDLE and start during DRAIN → err_stray=1, SRAM not written, drain unaffected; next start clears err_stray.
- Reset mid-DRAIN: assert rst_n=0 after 2 beats → all outputs at reset values next edge; a new job then runs cleanly from address 0.
